disp_scan_n: RTL and testbench

- Parametrised N-digit multiplexed seven-segment display driver; successor to the fixed 4-digit display path on the board top level.
- Scans one digit per prescaler period and decodes hex to active-low segments.
- Adds a per-digit enable mask, per-digit decimal points, leading-zero blanking, and double-buffered loading committed only at frame boundaries, with a load acknowledge.
- Sits between user logic (switch/counter values) and the board AN/SEGMENT pins.

---
 rtl/disp_scan_n_pkg.sv | 27 ++
 rtl/disp_scan_n_if.sv | 26 ++
 rtl/disp_scan_n_seg7_decode.sv | 17 +
 rtl/disp_scan_n.sv | 132 +++++++++++++
 tb/tb_disp_scan_n.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/disp_scan_n_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: segment bit
// positions, the blank pattern and the hex-to-segment table (active-low).
package disp_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Index = hex value; dp bit (bit 7) is 1 (off) in every entry.
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/disp_scan_n_if.sv
// Bundle of user-side data/control and board-side AN/SEGMENT pins for the scanner.
interface disp_scan_n_if #(
  parameter int unsigned N_DIGITS = 4
);

  logic [4*N_DIGITS-1:0] data_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   en_mask;
  logic                  lz_blank;
  logic                  load;
  logic                  load_ack;
  logic                  frame_start;
  logic [N_DIGITS-1:0]   AN;
  logic [7:0]            SEGMENT;

  modport master (
    output data_in, dp_in, en_mask, lz_blank, load,
    input  load_ack, frame_start, AN, SEGMENT
  );

  modport slave (
    input  data_in, dp_in, en_mask, lz_blank, load,
    output load_ack, frame_start, AN, SEGMENT
  );

endinterface

// File: rtl/disp_scan_n_seg7_decode.sv
// Combinational hex + dp + blank to active-low segment pattern.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0]       nibble_i,
  input  logic             dp_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_c_o
);

  always_comb begin
    seg_c_o         = hex_to_seg(nibble_i);
    seg_c_o[SEG_DP] = ~dp_i;
    if (blank_i) seg_c_o = SEG_BLANK;
  end

endmodule

// File: rtl/disp_scan_n.sv
// N-digit multiplexed seven-segment driver with double-buffered loads committed
// at frame wrap, per-digit enable/dp and live leading-zero blanking.
module disp_scan_n
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  disp_scan_n_if.slave  bus
);

  localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned DW = 4 * N_DIGITS;

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  // Enables are held as disable bits so the reset value (0) lights every digit.
  logic [DW-1:0]       act_data_q, act_data_d, stg_data_q, stg_data_d;
  logic [N_DIGITS-1:0] act_dp_q, act_dp_d, stg_dp_q, stg_dp_d;
  logic [N_DIGITS-1:0] act_dis_q, act_dis_d, stg_dis_q, stg_dis_d;
  logic                pending_q, pending_d;
  logic                wrap_q, commit_q;
  logic                load_ack_q, frame_start_q;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]    seg_q;

  logic                tc, wrap, commit;
  logic [N_DIGITS-1:0] dark_all;
  logic                seen_nz;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_dark;
  logic [SEG_W-1:0]    seg_c;

  // Scan timing, staging and commit.
  always_comb begin
    tc         = (presc_q == PW'(PRESCALE - 1));
    wrap       = tc && (idx_q == IW'(N_DIGITS - 1));
    commit     = wrap && pending_q;
    presc_d    = tc ? '0 : presc_q + PW'(1);
    idx_d      = idx_q;
    if (tc) idx_d = wrap ? '0 : idx_q + IW'(1);

    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_dis_d  = act_dis_q;
    if (commit) begin
      act_data_d = stg_data_q;
      act_dp_d   = stg_dp_q;
      act_dis_d  = stg_dis_q;
    end

    stg_data_d = stg_data_q;
    stg_dp_d   = stg_dp_q;
    stg_dis_d  = stg_dis_q;
    if (bus.load) begin
      stg_data_d = bus.data_in;
      stg_dp_d   = bus.dp_in;
      stg_dis_d  = ~bus.en_mask;
    end
    // A load coinciding with commit stays pending for the following frame.
    pending_d  = bus.load || (pending_q && !commit);
  end

  // Dark mask: disabled digits, plus leading zeros scanned from the top.
  always_comb begin
    seen_nz  = 1'b0;
    dark_all = '0;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      if (!act_dis_q[i] && (act_data_q[4*i +: 4] != 4'h0)) seen_nz = 1'b1;
      dark_all[i] = act_dis_q[i] || (bus.lz_blank && !seen_nz && (i != 0));
    end
  end

  always_comb begin
    cur_nib  = act_data_q[{idx_q, 2'b00} +: 4];
    cur_dp   = act_dp_q[idx_q];
    cur_dark = dark_all[idx_q];
    an_d     = cur_dark ? '1 : ~(N_DIGITS'(1) << idx_q);
  end

  seg7_decode u_dec (
    .nibble_i (cur_nib),
    .dp_i     (cur_dp),
    .blank_i  (cur_dark),
    .seg_c_o  (seg_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_dis_q     <= '0;
      stg_data_q    <= '0;
      stg_dp_q      <= '0;
      stg_dis_q     <= '0;
      pending_q     <= 1'b0;
      wrap_q        <= 1'b0;
      commit_q      <= 1'b0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_dis_q     <= act_dis_d;
      stg_data_q    <= stg_data_d;
      stg_dp_q      <= stg_dp_d;
      stg_dis_q     <= stg_dis_d;
      pending_q     <= pending_d;
      wrap_q        <= wrap;
      commit_q      <= commit;
      load_ack_q    <= commit_q;
      frame_start_q <= wrap_q;
      an_q          <= an_d;
      seg_q         <= seg_c;
    end
  end

  assign bus.AN          = an_q;
  assign bus.SEGMENT     = seg_q;
  assign bus.load_ack    = load_ack_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_disp_scan_n.sv
// Self-checking bench for disp_scan_n (4 digits, prescale 4): vector table of
// loads checked frame by frame through a scoreboard, plus multi-cycle corners.
module tb_disp_scan_n;

  localparam int unsigned ND = 4;
  localparam int unsigned PS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  disp_scan_n_if #(.N_DIGITS(ND)) bus ();

  disp_scan_n #(.N_DIGITS(ND), .PRESCALE(PS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [31:0] segs;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  dark;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] prev_an3;
  logic [7:0] prev_seg3;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    bus.data_in = d;
    bus.dp_in   = dp;
    bus.en_mask = en;
  endtask

  task automatic push_exp(input logic [31:0] segs, input logic [3:0] dark);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.an  = dark[i] ? 4'hF : ~(4'b0001 << i);
      e.seg = segs[8*i +: 8];
      sb.push_back(e);
    end
  endtask

  task automatic do_load();
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  // Returns at the frame_start cycle; reports the display just before it.
  task automatic wait_frame(input string name, output logic [3:0] an_b, output logic [7:0] seg_b);
    int k;
    k     = 0;
    an_b  = bus.AN;
    seg_b = bus.SEGMENT;
    while (bus.frame_start !== 1'b1 && k < 40) begin
      an_b  = bus.AN;
      seg_b = bus.SEGMENT;
      tick();
      k++;
    end
    if (k >= 40) chk({name, "_timeout"}, 32'(bus.frame_start), 32'd1);
  endtask

  // Called at a frame_start cycle; samples each digit's first dwell cycle.
  task automatic check_digits(input string name);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (PS) tick();
      if (sb.size() == 0) begin
        chk({name, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s_an%0d", name, i), 32'(bus.AN), 32'(e.an));
        chk($sformatf("%s_seg%0d", name, i), 32'(bus.SEGMENT), 32'(e.seg));
      end
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [3:0] a;
    logic [7:0] s;

    vecs[0] = '{16'h1A80, 4'b0010, 4'b1111, 1'b0, 32'hF9_88_00_C0, 4'b0000};
    vecs[1] = '{16'h0030, 4'b0000, 4'b1111, 1'b1, 32'hFF_FF_B0_C0, 4'b1100};
    vecs[2] = '{16'h0507, 4'b0000, 4'b1011, 1'b1, 32'hFF_FF_FF_F8, 4'b1110};
    vecs[3] = '{16'h0000, 4'b1001, 4'b1111, 1'b1, 32'hFF_FF_FF_40, 4'b1110};
    vecs[4] = '{16'h1234, 4'b1111, 4'b0000, 1'b0, 32'hFF_FF_FF_FF, 4'b1111};
    vecs[5] = '{16'hCDEF, 4'b0101, 4'b1111, 1'b0, 32'hC6_21_86_0E, 4'b0000};
    vecs[6] = '{16'h4562, 4'b0000, 4'b0110, 1'b1, 32'hFF_92_82_FF, 4'b1001};

    drive(16'h0, 4'h0, 4'h0);
    bus.lz_blank = 1'b0;
    bus.load     = 1'b0;

    // Reset state, then free-running scan of all-zero data.
    tick(); tick(); tick();
    chk("rst_an", 32'(bus.AN), 32'hF);
    chk("rst_seg", 32'(bus.SEGMENT), 32'hFF);
    chk("rst_ack", 32'(bus.load_ack), 32'd0);
    chk("rst_fs", 32'(bus.frame_start), 32'd0);
    rst_n = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 1)  chk("scan_an_c1", 32'(bus.AN), 32'hE);
      if (c == 1)  chk("scan_seg_c1", 32'(bus.SEGMENT), 32'hC0);
      if (c == 4)  chk("scan_an_c4", 32'(bus.AN), 32'hE);
      if (c == 5)  chk("scan_an_c5", 32'(bus.AN), 32'hD);
      if (c == 9)  chk("scan_an_c9", 32'(bus.AN), 32'hB);
      if (c == 13) chk("scan_an_c13", 32'(bus.AN), 32'h7);
      if (c == 16) chk("scan_fs_c16", 32'(bus.frame_start), 32'd0);
      if (c == 17) chk("scan_fs_c17", 32'(bus.frame_start), 32'd1);
      if (c == 17) chk("scan_ack_c17", 32'(bus.load_ack), 32'd0);
      if (c == 17) chk("scan_an_c17", 32'(bus.AN), 32'hE);
      if (c == 18) chk("scan_fs_c18", 32'(bus.frame_start), 32'd0);
    end
    repeat (11) tick();   // digit 3 of the second frame
    prev_an3  = 4'h7;
    prev_seg3 = 8'hC0;

    // Table: load mid-frame, old data up to the wrap, then the new frame.
    foreach (vecs[v]) begin
      drive(vecs[v].data, vecs[v].dp, vecs[v].en);
      push_exp(vecs[v].segs, vecs[v].dark);
      do_load();
      wait_frame($sformatf("v%0d", v), a, s);
      chk($sformatf("v%0d_old_an", v), 32'(a), 32'(prev_an3));
      chk($sformatf("v%0d_old_seg", v), 32'(s), 32'(prev_seg3));
      chk($sformatf("v%0d_ack", v), 32'(bus.load_ack), 32'd1);
      bus.lz_blank = vecs[v].lz;
      check_digits($sformatf("v%0d", v));
      prev_an3  = vecs[v].dark[3] ? 4'hF : 4'h7;
      prev_seg3 = vecs[v].segs[31:24];
    end

    // Two loads before one wrap: second overwrites, single ack.
    drive(16'h1111, 4'h0, 4'hF);
    push_exp(32'hF9F9F9F9, 4'b0000);
    do_load();
    drive(16'h2222, 4'h0, 4'hF);
    repeat (4) void'(sb.pop_back());
    push_exp(32'hA4A4A4A4, 4'b0000);
    do_load();
    wait_frame("dbl", a, s);
    chk("dbl_ack", 32'(bus.load_ack), 32'd1);
    bus.lz_blank = 1'b0;
    check_digits("dbl");

    // Load exactly in the commit cycle with nothing pending.
    tick(); tick();
    drive(16'h3456, 4'h0, 4'hF);
    push_exp(32'hB0_99_92_82, 4'b0000);
    do_load();
    wait_frame("cc1", a, s);
    chk("cc1_noack", 32'(bus.load_ack), 32'd0);
    chk("cc1_seg_old", 32'(bus.SEGMENT), 32'hA4);
    tick();
    wait_frame("cc2", a, s);
    chk("cc2_old_seg", 32'(s), 32'hA4);
    chk("cc2_ack", 32'(bus.load_ack), 32'd1);
    check_digits("cc2");

    // Reset mid-frame with a load pending, just before its commit edge.
    drive(16'h8888, 4'h0, 4'hF);
    push_exp(32'h80808080, 4'b0000);
    do_load();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_an", 32'(bus.AN), 32'hF);
    chk("mrst_seg", 32'(bus.SEGMENT), 32'hFF);
    chk("mrst_ack", 32'(bus.load_ack), 32'd0);
    chk("mrst_fs", 32'(bus.frame_start), 32'd0);
    sb.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_rel_an", 32'(bus.AN), 32'hE);
    chk("mrst_rel_seg", 32'(bus.SEGMENT), 32'hC0);
    wait_frame("mrst", a, s);
    chk("mrst_f1_ack", 32'(bus.load_ack), 32'd0);
    chk("mrst_f1_seg", 32'(bus.SEGMENT), 32'hC0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
